tx_uart_fifo: RTL
=================

// Module: tx_uart_fifo
// PURPOSE
//  Serial 8N1 transmitter with runtime baud divisor and an internal byte FIFO. Host logic
//  pushes bytes with a single-cycle strobe; the block drains the FIFO onto tx_pin, LSB first,
//  back-to-back with no idle gap. Bit timing matches the block's companion receiver:
//  one bit = baud_div+1 clk cycles.
// PARAMETERS
//  FIFO_AW   4   log2 of FIFO depth (depth = 2**FIFO_AW = 16 bytes)
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst_n        in   1          asynchronous, active-low reset
//  baud_div     in   16         cycles per bit minus one (F_CLK/BAUD - 1)
//  tx_data      in   8          byte to enqueue
//  tx_start     in   1          push strobe; tx_data enqueued when tx_start && tx_ready
//  tx_ready     out  1          FIFO not full (count < 2**FIFO_AW)
//  tx_busy      out  1          1 while FIFO non-empty or FSM not IDLE
//  tx_overflow  out  1          1-cycle pulse: tx_start while full, byte dropped
//  tx_level     out  FIFO_AW+1  bytes currently queued (excludes byte on the wire)
//  tx_pin       out  1          serial output, idle high, registered
//  parity_odd   in   1          only with TX_PARITY_EN: 1 = odd, 0 = even parity
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): tx_pin=1, FSM=IDLE, FIFO flushed (rd=wr=0,
//   level=0), tx_ready=1, tx_busy=0, tx_overflow=0, bit_timer=0, bit_index=0.
//  FIFO: circular, ptrs FIFO_AW bits wrap naturally; count FIFO_AW+1 bits.
//   Push when tx_start && !full; pop only from FSM when count>0. Push+pop same edge:
//   count unchanged. tx_start when full: no write, tx_overflow=1 next cycle, even if a
//   pop occurs on the same edge (tx_ready is judged on pre-edge count).
//  FSM states: IDLE, START, DATA, [PARITY], STOP.
//   IDLE : if count>0 -> pop byte into shift reg, tx_pin<=0, bit_timer<=baud_div, ->START.
//          Latency: push at edge E into empty FIFO while IDLE -> tx_pin falls at edge E+1.
//   START: bit_timer==0 -> tx_pin<=shift[0], bit_timer<=baud_div, bit_index<=0, ->DATA;
//          else bit_timer-1.
//   DATA : bit_timer==0 -> if bit_index<7: bit_index+1, tx_pin<=next bit;
//          else tx_pin<=1 (->STOP) or parity bit (->PARITY); bit_timer<=baud_div.
//   PARITY: bit_timer==0 -> tx_pin<=1, bit_timer<=baud_div, ->STOP.
//   STOP : bit_timer==0 -> if count>0 pop next byte, tx_pin<=0, ->START (no gap);
//          else ->IDLE with tx_pin=1.
//  Every bit (start/data/parity/stop) lasts exactly baud_div+1 cycles. baud_div is sampled
//   at each bit reload; a mid-frame change affects the next bit only. baud_div=0 -> 1 cycle/bit.
//  Frame length: 10*(baud_div+1) cycles (11* with parity).
//  tx_busy combinational from registered state/count; tx_level = count.
//  Illegal FSM encoding -> IDLE with tx_pin=1.
// CONFIGURATION
//  TX_PARITY_EN defined: PARITY state inserted after bit 7; parity bit = ^byte ^ parity_odd;
//   parity_odd port exists, sampled at pop. Undefined: pure 8N1, no PARITY state,
//   no parity_odd port.
// TESTING
//  baud_div=9, push 0xA5 idle -> tx_pin low 1 cycle after push; bits 0,1,0,1,0,0,1,0,1,1,
//   10 cycles each; tx_busy low after cycle 100.
//  Push 0x00,0xFF,0x55 consecutive cycles -> 3 frames back-to-back, no high gap between
//   stop and next start; tx_level peaks at 2.
//  Hold tx_start 18 cycles at baud_div=99 -> 16 queued plus 1 popped; 18th push ->
//   tx_ready=0, tx_overflow pulse; last byte dropped; 17 frames total.
//  baud_div=0, push 0x3C -> 10-cycle frame, 1 cycle per bit, correct bit order.
//  Assert rst_n low during bit 4 of 0x81 with 3 bytes queued -> tx_pin=1 immediately,
//   level=0, no further frames after release.
//  TX_PARITY_EN, parity_odd=0, push 0x07 -> parity bit 1, stop after it, 11*(baud_div+1)
//   cycles; parity_odd=1 -> parity bit 0.

Source files
------------

// File: rtl/tx_uart_fifo_if.sv
// ---------------------------------------------------------------------------
// tx_uart_fifo_if
// Host-side byte interface of the UART transmitter.
//
// Handshake: tx_start is the valid strobe and tx_ready is the ready signal.
// A byte (tx_data) transfers on the rising clk edge where both are high.
// A tx_start seen while tx_ready is low does not stall. The byte is dropped,
// and tx_overflow pulses high for the following cycle.
//
// Signals
//   tx_data     host -> tx   byte to enqueue
//   tx_start    host -> tx   push strobe
//   tx_ready    tx -> host   FIFO not full
//   tx_busy     tx -> host   bytes queued or a frame on the wire
//   tx_overflow tx -> host   1-cycle pulse: push attempted while full
//   tx_level    tx -> host   bytes queued (not counting the one on the wire)
// Modports: master = host logic, slave = transmitter.
// ---------------------------------------------------------------------------
interface tx_uart_fifo_if #(
   parameter int FIFO_AW = 4
) ();
   logic [7:0]       tx_data;
   logic             tx_start;
   logic             tx_ready;
   logic             tx_busy;
   logic             tx_overflow;
   logic [FIFO_AW:0] tx_level;

   modport master (
      output tx_data, tx_start,
      input  tx_ready, tx_busy, tx_overflow, tx_level
   );

   modport slave (
      input  tx_data, tx_start,
      output tx_ready, tx_busy, tx_overflow, tx_level
   );
endinterface

// File: rtl/tx_uart_fifo.sv
// ---------------------------------------------------------------------------
// tx_uart_fifo
// Serial 8N1 transmitter with a 2**FIFO_AW byte FIFO and a runtime baud divisor.
// Frames go out LSB first. Queued bytes are sent back-to-back with no idle gap.
// Each bit lasts baud_div+1 clk cycles.
//
// Optional feature: define TX_PARITY_EN to add a parity bit after data bit 7
// (parity = ^byte ^ parity_odd, with parity_odd sampled when the byte is popped).
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   baud_div   in   cycles per bit minus one, reloaded at every bit boundary
//   parity_odd in   (TX_PARITY_EN only) 1 = odd, 0 = even parity
//   host       slave modport of tx_uart_fifo_if (push side, status)
//   tx_pin     out  registered serial line, idle high
//   fsm_state  out  current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module tx_uart_fifo #(
   parameter int FIFO_AW = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0]         baud_div,
`ifdef TX_PARITY_EN
   input  logic                parity_odd,
`endif
   tx_uart_fifo_if.slave       host,
   output logic                tx_pin,
   output logic [2:0]          fsm_state
);
   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               full, empty, push, pop;
   logic [15:0]        bit_timer, timer_nx;
   logic [2:0]         bit_index, index_nx;
   logic [7:0]         shift_q, shift_nx;
   logic               pin_nx, overflow_q, timer_done;
`ifdef TX_PARITY_EN
   logic               par_q, par_nx;
`endif

   assign full       = (count == (FIFO_AW + 1)'(DEPTH));
   assign empty      = (count == '0);
   // Fullness is judged on the pre-edge count, so a same-edge pop never
   // rescues a push into a full FIFO.
   assign push       = host.tx_start && !full;
   assign timer_done = (bit_timer == 16'd0);

   assign host.tx_ready    = !full;
   assign host.tx_busy     = !empty || (state != S_IDLE);
   assign host.tx_overflow = overflow_q;
   assign host.tx_level    = count;
   assign fsm_state        = state;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (!empty) state_nx = S_START;
         S_START:  if (timer_done) state_nx = S_DATA;
         S_DATA: begin
            if (timer_done && bit_index == 3'd7) begin
`ifdef TX_PARITY_EN
               state_nx = S_PARITY;
`else
               state_nx = S_STOP;
`endif
            end
         end
`ifdef TX_PARITY_EN
         S_PARITY: if (timer_done) state_nx = S_STOP;
`endif
         S_STOP:   if (timer_done) state_nx = empty ? S_IDLE : S_START;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      pop      = 1'b0;
      pin_nx   = tx_pin;
      timer_nx = bit_timer;
      index_nx = bit_index;
      shift_nx = shift_q;
`ifdef TX_PARITY_EN
      par_nx   = par_q;
`endif
      case (state)
         S_IDLE: begin
            pin_nx = 1'b1;
            pop    = !empty;
         end
         S_START: begin
            if (timer_done) begin
               pin_nx   = shift_q[0];
               timer_nx = baud_div;
               index_nx = 3'd0;
            end else begin
               timer_nx = bit_timer - 16'd1;
            end
         end
         S_DATA: begin
            if (timer_done) begin
               timer_nx = baud_div;
               if (bit_index != 3'd7) begin
                  index_nx = bit_index + 3'd1;
                  pin_nx   = shift_q[index_nx];
               end else begin
`ifdef TX_PARITY_EN
                  pin_nx = par_q;
`else
                  pin_nx = 1'b1;
`endif
               end
            end else begin
               timer_nx = bit_timer - 16'd1;
            end
         end
`ifdef TX_PARITY_EN
         S_PARITY: begin
            if (timer_done) begin
               pin_nx   = 1'b1;
               timer_nx = baud_div;
            end else begin
               timer_nx = bit_timer - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (timer_done) begin
               pin_nx = 1'b1;
               pop    = !empty;
            end else begin
               timer_nx = bit_timer - 16'd1;
            end
         end
         default: begin
            pin_nx   = 1'b1;
            timer_nx = 16'd0;
            index_nx = 3'd0;
         end
      endcase
      // A pop always begins a new frame: load the byte and drive the start bit.
      if (pop) begin
         shift_nx = mem[rd_ptr];
         pin_nx   = 1'b0;
         timer_nx = baud_div;
`ifdef TX_PARITY_EN
         par_nx   = ^mem[rd_ptr] ^ parity_odd;
`endif
      end
   end

   // FIFO storage needs no reset; the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host.tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_pin     <= 1'b1;
         bit_timer  <= 16'd0;
         bit_index  <= 3'd0;
         shift_q    <= 8'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
`ifdef TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         tx_pin     <= pin_nx;
         bit_timer  <= timer_nx;
         bit_index  <= index_nx;
         shift_q    <= shift_nx;
         overflow_q <= host.tx_start && full;
`ifdef TX_PARITY_EN
         par_q      <= par_nx;
`endif
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW + 1)'(1);
            2'b01:   count <= count - (FIFO_AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule
